serial_subtractor_24bit: RTL and testbench
==========================================

SERIAL_SUBTRACTOR_24BIT -- requirements
Module: serial_subtractor_24bit

Interface
REQ-001 Parameter WIDTH, default 24, operand and result width in bits; all widths below are WIDTH unless stated.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request to begin a subtraction; sampled each rising edge.
REQ-005 a  input  WIDTH  minuend, unsigned.
REQ-006 b  input  WIDTH  subtrahend, unsigned.
REQ-007 borrow_in  input  1  incoming borrow, subtracted at bit 0.
REQ-008 busy  output  1  high while a subtraction is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 diff  output  WIDTH  result a - b - borrow_in, modulo 2^WIDTH.
REQ-011 borrow_out  output  1  borrow out of bit WIDTH-1; set when a < b + borrow_in.

Function
REQ-012 The block SHALL use three states: IDLE, SHIFT, DONE; reset state IDLE.
REQ-013 In IDLE with start=1 at edge N, the block SHALL latch a, b, borrow_in into internal registers, clear the bit counter, and enter SHIFT.
REQ-014 start SHALL be ignored in SHIFT and DONE; latched operands SHALL not change until the next accepted start.
REQ-015 In SHIFT, each edge SHALL process one bit, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); br initialised to borrow_in.
REQ-016 Edges N+1 .. N+WIDTH SHALL process bits 0 .. WIDTH-1; edge N+WIDTH SHALL transfer the assembled result to diff and the final borrow to borrow_out, and enter DONE.
REQ-017 busy SHALL be high exactly in SHIFT (WIDTH cycles, following edges N+1 .. N+WIDTH-1 and N... i.e. from edge N to edge N+WIDTH).
REQ-018 done SHALL be high exactly in DONE, for one cycle after edge N+WIDTH; DONE SHALL return to IDLE unconditionally at the next edge.
REQ-019 diff and borrow_out SHALL change only at completion (REQ-016) or reset, and SHALL hold between operations.
REQ-020 Minimum start-to-start spacing SHALL be WIDTH+2 cycles; start asserted in the first IDLE cycle after DONE SHALL be accepted.
REQ-021 Bit counter SHALL be ceil(log2(WIDTH)) bits wide and SHALL not wrap within an operation.

Reset
REQ-022 With rst_n=0 at an edge: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, counter and operand registers=0.
REQ-023 rst_n=0 during SHIFT SHALL abort the operation; no done pulse SHALL follow; reset SHALL take priority over start.

Configuration
REQ-024 Macro SUB_SATURATE_EN, when defined: if final borrow is 1, diff SHALL load all-zeros (borrow_out still 1).
REQ-025 Without SUB_SATURATE_EN: diff SHALL load the wrapped modulo-2^WIDTH result; cycle timing identical in both builds.

Verification
REQ-026 a=5, b=3, borrow_in=0, start -> after 24 busy cycles, done pulse, diff=0x000002, borrow_out=0.
REQ-027 a=0, b=1, borrow_in=0 -> diff=0xFFFFFF, borrow_out=1; with SUB_SATURATE_EN diff=0x000000, borrow_out=1.
REQ-028 a=0xFFFFFF, b=0xFFFFFF, borrow_in=1 -> diff=0xFFFFFF, borrow_out=1 (saturated build: 0x000000).
REQ-029 start held high continuously with changing a/b during SHIFT -> result reflects operands at accepted edge only; next op accepted in the IDLE cycle after done.
REQ-030 rst_n=0 at bit 10 of op a=0x123456, b=0x000001 -> next cycle busy=0, done=0, diff=0, borrow_out=0; no done pulse follows.
REQ-031 Random a, b, borrow_in, 1000 operations -> diff and borrow_out match {borrow_out,diff} = {1'b0,a} - b - borrow_in (two's complement, 25 bits).

Source files
------------

// File: rtl/serial_subtractor_24bit.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first.
// Define SUB_SATURATE_EN to clamp diff to zero when the final borrow is set.
module serial_subtractor_24bit #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] res_nx;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_i;
    logic             b_i;
    logic             d_i;
    logic             br_nx;
    logic             last;

    // Operands stay static; the counter selects the bit being processed.
    always_comb begin
        a_i    = a_r[cnt];
        b_i    = b_r[cnt];
        d_i    = a_i ^ b_i ^ br;
        br_nx  = (~a_i & b_i) | (~(a_i ^ b_i) & br);
        res_nx = {d_i, acc[WIDTH-1:1]};
        last   = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r        <= '0;
            b_r        <= '0;
            acc        <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                        br  <= borrow_in;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    acc <= res_nx;
                    br  <= br_nx;
                    if (last) begin
                        borrow_out <= br_nx;
`ifdef SUB_SATURATE_EN
                        diff <= br_nx ? '0 : res_nx;
`else
                        diff <= res_nx;
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_24bit.sv
// Self-checking bench for serial_subtractor_24bit.
// Randomised and directed operations checked against an arithmetic model.
module tb_serial_subtractor_24bit;

    localparam int W = 24;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         borrow_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_diff;
    logic         exp_bo;

    serial_subtractor_24bit #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] model(logic [W-1:0] x, logic [W-1:0] y,
                                         logic bi);
        logic [W:0] r;
        r = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
`ifdef SUB_SATURATE_EN
        if (r[W]) r[W-1:0] = '0;
`endif
        return r;
    endfunction

    // Starts at a negedge in IDLE; returns at the negedge of the IDLE cycle after done.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, input bit hold, input string name);
        logic [W:0] r;
        r = model(ta, tb_, tbin);
        a = ta;
        b = tb_;
        borrow_in = tbin;
        start = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            if (hold) begin
                start = 1'b1;
                a = W'($urandom);
                b = W'($urandom);
                borrow_in = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            total++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== exp_diff ||
                borrow_out !== exp_bo) begin
                bad++;
                $display("FAIL %s shift cyc %0d: busy=%b done=%b diff=%h bo=%b want busy=1 done=0 diff=%h bo=%b",
                         name, i, busy, done, diff, borrow_out, exp_diff, exp_bo);
            end
        end
        @(negedge clk);
        exp_diff = r[W-1:0];
        exp_bo   = r[W];
        total++;
        if (busy !== 1'b0 || done !== 1'b1 || diff !== exp_diff ||
            borrow_out !== exp_bo) begin
            bad++;
            $display("FAIL %s done: busy=%b done=%b diff=%h bo=%b want busy=0 done=1 diff=%h bo=%b",
                     name, busy, done, diff, borrow_out, exp_diff, exp_bo);
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== exp_diff ||
            borrow_out !== exp_bo) begin
            bad++;
            $display("FAIL %s idle: busy=%b done=%b diff=%h bo=%b want busy=0 done=0 diff=%h bo=%b",
                     name, busy, done, diff, borrow_out, exp_diff, exp_bo);
        end
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a = 24'h123456;
        b = 24'h000001;
        borrow_in = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b diff=%h bo=%b want all zero",
                     busy, done, diff, borrow_out);
        end
        start = 1'b0;
        rst_n = 1'b1;
        exp_diff = '0;
        exp_bo   = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        run_op(24'd5, 24'd3, 1'b0, 1'b0, "five_minus_three");
        run_op(24'd0, 24'd1, 1'b0, 1'b0, "zero_minus_one");
        run_op(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, "ones_borrow");
        run_op(24'hFFFFFF, 24'h000000, 1'b1, 1'b0, "max_minus_bin");
        run_op(24'h800000, 24'h7FFFFF, 1'b0, 1'b0, "msb_edge");
        run_op(24'h000000, 24'h000000, 1'b1, 1'b0, "zero_bin");
        // Idle gap: outputs must hold
        repeat (5) @(negedge clk);
        total++;
        if (diff !== exp_diff || borrow_out !== exp_bo || busy !== 1'b0) begin
            bad++;
            $display("FAIL hold_idle: diff=%h bo=%b busy=%b want diff=%h bo=%b busy=0",
                     diff, borrow_out, busy, exp_diff, exp_bo);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1, "held_start");
        end
        start = 1'b0;
    endtask

    task automatic test_abort();
        logic seen;
        a = 24'h123456;
        b = 24'h000001;
        borrow_in = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_diff = '0;
        exp_bo   = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow_out !== 1'b0) begin
            bad++;
            $display("FAIL abort: busy=%b done=%b diff=%h bo=%b want all zero",
                     busy, done, diff, borrow_out);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_no_done: activity seen=%b want 0", seen);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, "random");
            if ($urandom_range(3) == 0) @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        borrow_in = 1'b0;
        exp_diff = '0;
        exp_bo = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_back_to_back();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
